// File: rtl/regfile_write_arbiter.sv
// Single write port sequencer for the 16x16 register file: ALU writes win, colliding
// loads wait in a 2-entry FIFO, and buffered loads made stale by younger ALU writes are dropped.
module regfile_write_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [3:0]  alu_reg,
   input  logic [15:0] alu_data,
   input  logic        mem_valid,
   input  logic [3:0]  mem_reg,
   input  logic [15:0] mem_data,
   output logic        mem_ready,
   output logic        WriteReg,
   output logic [3:0]  DstReg,
   output logic [15:0] DstData,
   output logic [15:0] pending
);

   logic [3:0]       fifoReg  [DEPTH];
   logic [15:0]      fifoData [DEPTH];
   logic [DEPTH-1:0] fifoVld;
   logic             headPtr;
   logic             tailPtr;
   logic [1:0]       count;

   logic memAccept;
   logic fifoEmpty;
   logic aluWrite;
   logic pop;
   logic bypass;
   logic push;

   always_comb begin
      mem_ready = (count < 2'd2) & ~rst;
      memAccept = mem_valid & mem_ready;
      fifoEmpty = (count == 2'd0);
      aluWrite  = alu_valid & (alu_reg != 4'd0);
      // An ALU request to R0 still owns the slot, so the FIFO cannot drain then.
      pop       = ~alu_valid & ~fifoEmpty;
      bypass    = ~alu_valid & fifoEmpty & memAccept & (mem_reg != 4'd0);
      push      = memAccept & (mem_reg != 4'd0) & ~bypass;
      pending   = 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fifoVld[i]) pending[fifoReg[i]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         WriteReg <= 1'b0;
         DstReg   <= 4'd0;
         DstData  <= 16'd0;
         fifoVld  <= '0;
         headPtr  <= 1'b0;
         tailPtr  <= 1'b0;
         count    <= 2'd0;
         for (int i = 0; i < DEPTH; i++) begin
            fifoReg[i]  <= 4'd0;
            fifoData[i] <= 16'd0;
         end
      end else begin
         WriteReg <= 1'b0;
         if (aluWrite) begin
            WriteReg <= 1'b1;
            DstReg   <= alu_reg;
            DstData  <= alu_data;
         end else if (pop && fifoVld[headPtr]) begin
            WriteReg <= 1'b1;
            DstReg   <= fifoReg[headPtr];
            DstData  <= fifoData[headPtr];
         end else if (bypass) begin
            WriteReg <= 1'b1;
            DstReg   <= mem_reg;
            DstData  <= mem_data;
         end

         // Buffered loads are older than this ALU write; a load pushed this edge is younger
         // and the push below overrides the clear for its slot.
         if (aluWrite) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (fifoReg[i] == alu_reg) fifoVld[i] <= 1'b0;
            end
         end

         if (pop) begin
            fifoVld[headPtr] <= 1'b0;
            headPtr          <= ~headPtr;
         end

         if (push) begin
            fifoReg[tailPtr]  <= mem_reg;
            fifoData[tailPtr] <= mem_data;
            fifoVld[tailPtr]  <= 1'b1;
            tailPtr           <= ~tailPtr;
         end

         if (push && !pop)      count <= count + 2'd1;
         else if (pop && !push) count <= count - 2'd1;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a table of per-cycle vectors with
// hand-computed expectations, plus a wrap-around burst sequence checked against a small queue model.
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0;
   logic [3:0]  alu_reg = 4'd0;
   logic [15:0] alu_data = 16'd0;
   logic        mem_valid = 1'b0;
   logic [3:0]  mem_reg = 4'd0;
   logic [15:0] mem_data = 16'd0;
   logic        mem_ready;
   logic        WriteReg;
   logic [3:0]  DstReg;
   logic [15:0] DstData;
   logic [15:0] pending;

   int nCmp = 0;
   int nBad = 0;

   regfile_write_arbiter #(.DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
      .mem_ready(mem_ready),
      .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
      .pending(pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        aV;
      logic [3:0]  aR;
      logic [15:0] aD;
      logic        mV;
      logic [3:0]  mR;
      logic [15:0] mD;
      logic        eW;
      logic        chkDst;
      logic [3:0]  eR;
      logic [15:0] eD;
      logic [15:0] ePend;
      logic        eRdy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic aV, logic [3:0] aR, logic [15:0] aD,
                               logic mV, logic [3:0] mR, logic [15:0] mD,
                               logic eW, logic chkDst, logic [3:0] eR, logic [15:0] eD,
                               logic [15:0] ePend, logic eRdy);
      vec_t v;
      v.rst = r; v.aV = aV; v.aR = aR; v.aD = aD;
      v.mV = mV; v.mR = mR; v.mD = mD;
      v.eW = eW; v.chkDst = chkDst; v.eR = eR; v.eD = eD;
      v.ePend = ePend; v.eRdy = eRdy;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s step %0d: got 0x%04h, expected 0x%04h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic aV, input logic [3:0] aR, input logic [15:0] aD,
                        input logic mV, input logic [3:0] mR, input logic [15:0] mD);
      rst = r; alu_valid = aV; alu_reg = aR; alu_data = aD;
      mem_valid = mV; mem_reg = mR; mem_data = mD;
   endtask

   initial begin
      logic [3:0]  qReg[$];
      logic [15:0] qData[$];
      logic [15:0] expPend;
      int          n;
      int          step;

      // rst, aV, aR, aD, mV, mR, mD, | eW, chkDst, eR, eD, ePend, eRdy
      // Reset held two cycles with arbitrary traffic
      vecs.push_back(mk(1, 1, 4'd5, 16'h1234, 1, 4'd3, 16'h5678,  0, 1, 4'd0, 16'h0000, 16'h0000, 0));
      vecs.push_back(mk(1, 1, 4'd9, 16'hCAFE, 1, 4'd6, 16'h7777,  0, 1, 4'd0, 16'h0000, 16'h0000, 0));
      vecs.push_back(mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000,  0, 1, 4'd0, 16'h0000, 16'h0000, 1));
      // Bypass load
      vecs.push_back(mk(0, 0, 4'd0, 16'h0000, 1, 4'd3, 16'hBEEF,  1, 1, 4'd3, 16'hBEEF, 16'h0000, 1));
      vecs.push_back(mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000,  0, 1, 4'd3, 16'hBEEF, 16'h0000, 1));
      // Collision and backpressure
      vecs.push_back(mk(0, 1, 4'd1, 16'h0001, 1, 4'd4, 16'h0044,  1, 1, 4'd1, 16'h0001, 16'h0010, 1));
      vecs.push_back(mk(0, 1, 4'd1, 16'h0001, 1, 4'd5, 16'h0055,  1, 1, 4'd1, 16'h0001, 16'h0030, 0));
      vecs.push_back(mk(0, 1, 4'd1, 16'h0001, 1, 4'd6, 16'h0066,  1, 1, 4'd1, 16'h0001, 16'h0030, 0));
      vecs.push_back(mk(0, 1, 4'd1, 16'h0001, 1, 4'd6, 16'h0066,  1, 1, 4'd1, 16'h0001, 16'h0030, 0));
      vecs.push_back(mk(0, 0, 4'd0, 16'h0000, 1, 4'd6, 16'h0066,  1, 1, 4'd4, 16'h0044, 16'h0020, 1));
      vecs.push_back(mk(0, 0, 4'd0, 16'h0000, 1, 4'd6, 16'h0066,  1, 1, 4'd5, 16'h0055, 16'h0040, 1));
      vecs.push_back(mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000,  1, 1, 4'd6, 16'h0066, 16'h0000, 1));
      // Stale cancel
      vecs.push_back(mk(0, 1, 4'd2, 16'h0BAD, 1, 4'd7, 16'h1111,  1, 1, 4'd2, 16'h0BAD, 16'h0080, 1));
      vecs.push_back(mk(0, 1, 4'd7, 16'h2222, 0, 4'd0, 16'h0000,  1, 1, 4'd7, 16'h2222, 16'h0000, 1));
      vecs.push_back(mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000,  0, 0, 4'd0, 16'h0000, 16'h0000, 1));
      vecs.push_back(mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000,  0, 0, 4'd0, 16'h0000, 16'h0000, 1));
      // R0 writes never reach the port; ALU-to-R0 still blocks the drain
      vecs.push_back(mk(0, 1, 4'd0, 16'hFFFF, 1, 4'd0, 16'h1234,  0, 0, 4'd0, 16'h0000, 16'h0000, 1));
      vecs.push_back(mk(0, 1, 4'd0, 16'hFFFF, 1, 4'd9, 16'h0999,  0, 0, 4'd0, 16'h0000, 16'h0200, 1));
      vecs.push_back(mk(0, 1, 4'd0, 16'hFFFF, 0, 4'd0, 16'h0000,  0, 0, 4'd0, 16'h0000, 16'h0200, 1));
      vecs.push_back(mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000,  1, 1, 4'd9, 16'h0999, 16'h0000, 1));
      vecs.push_back(mk(0, 0, 4'd0, 16'h0000, 1, 4'd0, 16'h1234,  0, 0, 4'd0, 16'h0000, 16'h0000, 1));
      // Same-cycle ALU write and younger load to the same reg
      vecs.push_back(mk(0, 1, 4'd3, 16'h0033, 1, 4'd8, 16'h0088,  1, 1, 4'd3, 16'h0033, 16'h0100, 1));
      vecs.push_back(mk(0, 1, 4'd8, 16'h8888, 1, 4'd8, 16'h8008,  1, 1, 4'd8, 16'h8888, 16'h0100, 0));
      vecs.push_back(mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000,  0, 0, 4'd0, 16'h0000, 16'h0100, 1));
      vecs.push_back(mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000,  1, 1, 4'd8, 16'h8008, 16'h0000, 1));
      // Reset mid-operation drops the buffered load
      vecs.push_back(mk(0, 1, 4'd1, 16'h0101, 1, 4'd10, 16'h0AAA, 1, 1, 4'd1, 16'h0101, 16'h0400, 1));
      vecs.push_back(mk(1, 1, 4'd2, 16'h0202, 1, 4'd11, 16'h0BBB, 0, 1, 4'd0, 16'h0000, 16'h0000, 0));
      vecs.push_back(mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000,  0, 1, 4'd0, 16'h0000, 16'h0000, 1));
      vecs.push_back(mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000,  0, 1, 4'd0, 16'h0000, 16'h0000, 1));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].aV, vecs[i].aR, vecs[i].aD, vecs[i].mV, vecs[i].mR, vecs[i].mD);
         @(posedge clk);
         #1;
         chk("WriteReg", i, 16'(WriteReg), 16'(vecs[i].eW));
         chk("pending", i, pending, vecs[i].ePend);
         chk("mem_ready", i, 16'(mem_ready), 16'(vecs[i].eRdy));
         if (vecs[i].chkDst) begin
            chk("DstReg", i, 16'(DstReg), 16'(vecs[i].eR));
            chk("DstData", i, DstData, vecs[i].eD);
         end
      end

      // Wrap-around: bursts of one or two collisions, then drain in acceptance order
      step = 1000;
      for (int k = 0; k < 10; k++) begin
         n = (k % 2) + 1;
         for (int j = 0; j < n; j++) begin
            logic [3:0]  lr;
            logic [15:0] ld;
            logic [15:0] ad;
            lr = 4'(4 + ((2 * k + j) % 10));
            ld = 16'(16'hA000 + k * 16 + j);
            ad = 16'(16'h1000 + k * 2 + j);
            drive(0, 1, 4'd1, ad, 1, lr, ld);
            qReg.push_back(lr);
            qData.push_back(ld);
            @(posedge clk);
            #1;
            expPend = 16'd0;
            foreach (qReg[m]) expPend[qReg[m]] = 1'b1;
            chk("wrap alu WriteReg", step, 16'(WriteReg), 16'd1);
            chk("wrap alu DstData", step, DstData, ad);
            chk("wrap pending", step, pending, expPend);
            chk("wrap mem_ready", step, 16'(mem_ready), (qReg.size() < 2) ? 16'd1 : 16'd0);
            step++;
         end
         for (int j = 0; j < n; j++) begin
            logic [3:0]  er;
            logic [15:0] ed;
            drive(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000);
            er = qReg.pop_front();
            ed = qData.pop_front();
            @(posedge clk);
            #1;
            expPend = 16'd0;
            foreach (qReg[m]) expPend[qReg[m]] = 1'b1;
            chk("wrap load WriteReg", step, 16'(WriteReg), 16'd1);
            chk("wrap load DstReg", step, 16'(DstReg), 16'(er));
            chk("wrap load DstData", step, DstData, ed);
            chk("wrap drain pending", step, pending, expPend);
            step++;
         end
      end

      drive(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000);
      @(posedge clk);
      #1;
      chk("final idle WriteReg", step, 16'(WriteReg), 16'd0);
      chk("final pending", step, pending, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
